arb_mux: RTL and testbench

Parametrised, registered M-way, N-bit channel selector that generalises the fixed 64-way combinational mux tree. It has per-channel valid/ready handshakes, a registered output stage with backpressure, and two run-time-fixed modes: explicit select and round-robin arbitration. It sits between multiple producers (register-file read ports, memory/peripheral response channels) and a single consumer in the datapath.

---
 rtl/arb_mux_pkg.sv | 10 +
 rtl/arb_mux_rr_pick.sv | 32 +++
 rtl/arb_mux.sv | 91 +++++++++
 tb/tb_arb_mux.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: mode encodings shared by the channel selector and its users.
package arb_mux_pkg;
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;
endpackage

// File: rtl/arb_mux_rr_pick.sv
// rr_pick: combinational rotating-priority encoder; picks the first request at or after ptr.
module rr_pick #(
    parameter int M  = 64,
    parameter int SW = $clog2(M)
) (
    input  logic [M-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] grant_idx,
    output logic          grant_any
);
    logic [SW:0]   w_sum;
    logic [SW-1:0] w_idx;

    // Offsets are scanned farthest-first so the requester nearest to ptr is assigned last.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int i = M - 1; i >= 0; i--) begin
            w_sum = {1'b0, ptr} + (SW+1)'(i);
            if (w_sum >= (SW+1)'(M)) begin
                w_sum = w_sum - (SW+1)'(M);
            end
            w_idx = w_sum[SW-1:0];
            if (req[w_idx]) begin
                grant_idx = w_idx;
                grant_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/arb_mux.sv
// arb_mux: M-way, N-bit registered channel selector with valid/ready handshakes,
// choosing the source by explicit select or by round-robin arbitration.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int N    = 32,
    parameter int M    = 64,
    parameter int MODE = MODE_FIXED,
    parameter int SW   = $clog2(M)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M*N-1:0] in_data,
    input  logic [M-1:0]   in_valid,
    output logic [M-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    output logic [N-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
);
    localparam arb_mode_e L_MODE = (MODE == MODE_RR) ? ARB_RR : ARB_FIXED;
    localparam int        DW     = $clog2(M*N);

    logic          r_out_valid;
    logic [N-1:0]  r_out_data;
    logic [SW-1:0] r_out_chan;

    logic          w_accept;
    logic          w_cand_any;
    logic          w_xfer_in;
    logic [SW-1:0] w_cand;
    logic [DW-1:0] w_base;
    logic [N-1:0]  w_data;

    assign w_accept = !r_out_valid || out_ready;

    generate
        if (L_MODE == ARB_RR) begin : g_rr
            logic [SW-1:0] r_ptr;

            rr_pick #(.M(M), .SW(SW)) u_pick (
                .req       (in_valid),
                .ptr       (r_ptr),
                .grant_idx (w_cand),
                .grant_any (w_cand_any)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (w_xfer_in) begin
                    r_ptr <= (w_cand == SW'(M - 1)) ? '0 : w_cand + SW'(1);
                end
            end
        end else begin : g_fixed
            // Select codes beyond the last channel name no source at all.
            assign w_cand     = sel;
            assign w_cand_any = ({1'b0, sel} < (SW+1)'(M));
        end
    endgenerate

    assign w_base    = DW'(w_cand) * DW'(N);
    assign w_data    = in_data[w_base +: N];
    assign w_xfer_in = w_cand_any && w_accept && in_valid[w_cand];

    always_comb begin
        in_ready = '0;
        if (w_cand_any) begin
            in_ready[w_cand] = w_accept;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_xfer_in) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_chan  <= w_cand;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: scoreboard bench over fixed-select (M=64, M=40) and round-robin (M=5, M=64) builds.
module tb_arb_mux;
    import arb_mux_pkg::*;

    typedef struct {
        int          chan;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   gq[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [64*32-1:0] f_data = '0;
    logic [63:0]      f_valid = '0, f_ready;
    logic [5:0]       f_sel = '0, f_ochan;
    logic [31:0]      f_odata;
    logic             f_ovalid, f_oready = 1'b0;

    logic [40*16-1:0] g_data = '0;
    logic [39:0]      g_valid = '0, g_ready;
    logic [5:0]       g_sel = '0, g_ochan;
    logic [15:0]      g_odata;
    logic             g_ovalid, g_oready = 1'b0;

    logic [5*8-1:0]   r5_data = '0;
    logic [4:0]       r5_valid = '0, r5_ready;
    logic [2:0]       r5_sel = '0, r5_ochan;
    logic [7:0]       r5_odata;
    logic             r5_ovalid, r5_oready = 1'b0;

    logic [64*16-1:0] r64_data = '0;
    logic [63:0]      r64_valid = '0, r64_ready;
    logic [5:0]       r64_sel = '0, r64_ochan;
    logic [15:0]      r64_odata;
    logic             r64_ovalid, r64_oready = 1'b0;

    arb_mux #(.N(32), .M(64), .MODE(MODE_FIXED)) d64f (
        .clk(clk), .rst(rst), .in_data(f_data), .in_valid(f_valid), .in_ready(f_ready),
        .sel(f_sel), .out_data(f_odata), .out_chan(f_ochan), .out_valid(f_ovalid), .out_ready(f_oready));

    arb_mux #(.N(16), .M(40), .MODE(MODE_FIXED)) d40f (
        .clk(clk), .rst(rst), .in_data(g_data), .in_valid(g_valid), .in_ready(g_ready),
        .sel(g_sel), .out_data(g_odata), .out_chan(g_ochan), .out_valid(g_ovalid), .out_ready(g_oready));

    arb_mux #(.N(8), .M(5), .MODE(MODE_RR)) d5r (
        .clk(clk), .rst(rst), .in_data(r5_data), .in_valid(r5_valid), .in_ready(r5_ready),
        .sel(r5_sel), .out_data(r5_odata), .out_chan(r5_ochan), .out_valid(r5_ovalid), .out_ready(r5_oready));

    arb_mux #(.N(16), .M(64), .MODE(MODE_RR)) d64r (
        .clk(clk), .rst(rst), .in_data(r64_data), .in_valid(r64_valid), .in_ready(r64_ready),
        .sel(r64_sel), .out_data(r64_odata), .out_chan(r64_ochan), .out_valid(r64_ovalid), .out_ready(r64_oready));

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({r64_ovalid, f_ovalid, g_ovalid, r5_ovalid} !== 4'b0 || r64_odata !== '0 || r64_ochan !== '0
            || f_odata !== '0 || f_ochan !== '0 || r5_odata !== '0) begin
            errors++;
            $display("FAIL reset_state: valids=%b r64 data=%h chan=%0d f data=%h, required all zero",
                     {r64_ovalid, f_ovalid, g_ovalid, r5_ovalid}, r64_odata, r64_ochan, f_odata);
        end
        rst = 1'b0;
        r64_valid  = 64'd1 << 4;
        r64_oready = 1'b0;
        @(negedge clk);
        checks++;
        if (r64_ovalid !== 1'b1 || r64_ochan !== 6'd4 || r64_odata !== 16'h1004) begin
            errors++;
            $display("FAIL reset_preload: valid=%b chan=%0d data=%h, required 1/4/1004", r64_ovalid, r64_ochan, r64_odata);
        end
        r64_valid = '0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (r64_ovalid !== 1'b0 || r64_odata !== '0 || r64_ochan !== '0) begin
            errors++;
            $display("FAIL reset_async: valid=%b data=%h chan=%0d, required 0/0/0", r64_ovalid, r64_odata, r64_ochan);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (r64_ready !== '0 || r5_ready !== '0) begin
            errors++;
            $display("FAIL idle_ready: r64=%h r5=%b, required 0", r64_ready, r5_ready);
        end
        r64_valid  = '1;
        r64_oready = 1'b1;
        #1;
        checks++;
        if (r64_ready !== 64'd1) begin
            errors++;
            $display("FAIL reset_ptr: in_ready=%h, required %h", r64_ready, 64'd1);
        end
        r64_valid  = '0;
        r64_oready = 1'b0;
    endtask

    task automatic test_fixed_select();
        int sels[4];
        sels = '{63, 0, 17, 42};
        sb.delete();
        f_oready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                checks++;
                if (f_ovalid !== 1'b1 || f_odata !== sb[0].data || f_ochan !== 6'(sb[0].chan)) begin
                    errors++;
                    $display("FAIL fixed_out: valid=%b data=%h chan=%0d, required 1/%h/%0d",
                             f_ovalid, f_odata, f_ochan, sb[0].data, sb[0].chan);
                end
                sb.pop_front();
            end
            if (i < 4) begin
                f_sel   = 6'(sels[i]);
                f_valid = 64'd1 << sels[i];
                sb.push_back('{chan: sels[i],
                               data: (sels[i] == 63) ? 32'hDEADBEEF : 32'h01010101 * 32'(sels[i])});
                #1;
                checks++;
                if (f_ready !== (64'd1 << sels[i])) begin
                    errors++;
                    $display("FAIL fixed_ready: in_ready=%h, required %h", f_ready, 64'd1 << sels[i]);
                end
            end else begin
                f_valid = '0;
            end
        end
        @(negedge clk);
        checks++;
        if (f_ovalid !== 1'b0) begin
            errors++;
            $display("FAIL fixed_drain: out_valid=%b, required 0", f_ovalid);
        end
        f_oready = 1'b0;
    endtask

    task automatic test_sel_oob();
        int bad[2];
        bad = '{40, 63};
        @(negedge clk);
        g_valid  = '1;
        g_oready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            g_sel = 6'(bad[i]);
            #1;
            checks++;
            if (g_ready !== '0) begin
                errors++;
                $display("FAIL oob_ready sel=%0d: in_ready=%h, required 0", bad[i], g_ready);
            end
            @(negedge clk);
            checks++;
            if (g_ovalid !== 1'b0) begin
                errors++;
                $display("FAIL oob_load sel=%0d: out_valid=%b, required 0", bad[i], g_ovalid);
            end
        end
        g_sel = 6'd39;
        #1;
        checks++;
        if (g_ready !== (40'd1 << 39)) begin
            errors++;
            $display("FAIL last_chan_ready: in_ready=%h, required %h", g_ready, 40'd1 << 39);
        end
        @(negedge clk);
        g_valid = '0;
        checks++;
        if (g_ovalid !== 1'b1 || g_ochan !== 6'd39 || g_odata !== 16'h4027) begin
            errors++;
            $display("FAIL last_chan_out: valid=%b chan=%0d data=%h, required 1/39/4027", g_ovalid, g_ochan, g_odata);
        end
        @(negedge clk);
        g_oready = 1'b0;
    endtask

    task automatic test_backpressure();
        sb.delete();
        @(negedge clk);
        f_sel    = 6'd5;
        f_valid  = 64'd1 << 5;
        f_oready = 1'b0;
        sb.push_back('{chan: 5, data: 32'h05050505});
        #1;
        checks++;
        if (f_ready !== (64'd1 << 5)) begin
            errors++;
            $display("FAIL bp_first_ready: in_ready=%h, required %h", f_ready, 64'd1 << 5);
        end
        @(negedge clk);
        f_sel   = 6'd6;
        f_valid = 64'd1 << 6;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (f_ready !== '0 || f_ovalid !== 1'b1 || f_odata !== sb[0].data || f_ochan !== 6'(sb[0].chan)) begin
                errors++;
                $display("FAIL bp_stall cycle %0d: ready=%h valid=%b data=%h chan=%0d, required 0/1/%h/%0d",
                         c, f_ready, f_ovalid, f_odata, f_ochan, sb[0].data, sb[0].chan);
            end
            @(negedge clk);
        end
        f_oready = 1'b1;
        sb.pop_front();
        sb.push_back('{chan: 6, data: 32'h06060606});
        #1;
        checks++;
        if (f_ready !== (64'd1 << 6)) begin
            errors++;
            $display("FAIL bp_release_ready: in_ready=%h, required %h", f_ready, 64'd1 << 6);
        end
        @(negedge clk);
        f_valid = '0;
        checks++;
        if (f_ovalid !== 1'b1 || f_odata !== sb[0].data || f_ochan !== 6'(sb[0].chan)) begin
            errors++;
            $display("FAIL bp_back_to_back: valid=%b data=%h chan=%0d, required 1/%h/%0d",
                     f_ovalid, f_odata, f_ochan, sb[0].data, sb[0].chan);
        end
        sb.pop_front();
        @(negedge clk);
        checks++;
        if (f_ovalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%b, required 0", f_ovalid);
        end
        f_oready = 1'b0;
    endtask

    task automatic test_rr_wrap();
        int seq[6];
        int guard;
        seq = '{1, 3, 4, 1, 3, 4};
        sb.delete();
        gq.delete();
        for (int i = 0; i < 6; i++) begin
            gq.push_back(seq[i]);
            sb.push_back('{chan: seq[i], data: 32'hA0 + 32'(seq[i])});
        end
        guard = 0;
        @(negedge clk);
        r5_valid  = 5'b11010;
        r5_oready = 1'b1;
        while (sb.size() > 0 && guard < 20) begin
            guard++;
            #1;
            if (gq.size() > 0) begin
                checks++;
                if (r5_ready !== (5'd1 << gq[0])) begin
                    errors++;
                    $display("FAIL rr_wrap_ready: in_ready=%b, required %b", r5_ready, 5'd1 << gq[0]);
                end
                gq.pop_front();
            end
            @(negedge clk);
            if (r5_ovalid) begin
                checks++;
                if (r5_ochan !== 3'(sb[0].chan) || r5_odata !== sb[0].data[7:0]) begin
                    errors++;
                    $display("FAIL rr_wrap_out: chan=%0d data=%h, required %0d/%h",
                             r5_ochan, r5_odata, sb[0].chan, sb[0].data[7:0]);
                end
                sb.pop_front();
            end
        end
        r5_valid = '0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rr_wrap_timeout: %0d words outstanding, required 0", sb.size());
        end
        @(negedge clk);
        r5_oready = 1'b0;
    endtask

    task automatic test_rr_fairness();
        int cnt[64];
        int guard;
        sb.delete();
        gq.delete();
        for (int k = 0; k < 64; k++) cnt[k] = 0;
        for (int i = 0; i < 128; i++) begin
            gq.push_back(i % 64);
            sb.push_back('{chan: i % 64, data: 32'h1000 + 32'(i % 64)});
        end
        guard = 0;
        @(negedge clk);
        r64_valid  = '1;
        r64_oready = 1'b1;
        while (sb.size() > 0 && guard < 200) begin
            guard++;
            #1;
            if (gq.size() > 0) begin
                checks++;
                if (r64_ready !== (64'd1 << gq[0])) begin
                    errors++;
                    $display("FAIL rr_fair_ready: in_ready=%h, required %h", r64_ready, 64'd1 << gq[0]);
                end
                gq.pop_front();
            end
            @(negedge clk);
            if (r64_ovalid) begin
                checks++;
                if (r64_ochan !== 6'(sb[0].chan) || r64_odata !== sb[0].data[15:0]) begin
                    errors++;
                    $display("FAIL rr_fair_out: chan=%0d data=%h, required %0d/%h",
                             r64_ochan, r64_odata, sb[0].chan, sb[0].data[15:0]);
                end
                cnt[r64_ochan]++;
                sb.pop_front();
            end
        end
        r64_valid = '0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rr_fair_timeout: %0d words outstanding, required 0", sb.size());
        end
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (cnt[k] != 2) begin
                errors++;
                $display("FAIL rr_fair_count ch %0d: granted %0d, required 2", k, cnt[k]);
            end
        end
        @(negedge clk);
        r64_oready = 1'b0;
    endtask

    task automatic test_ptr_hold();
        int guard;
        @(negedge clk);
        r64_valid  = 64'd1 << 7;
        r64_oready = 1'b1;
        #1;
        checks++;
        if (r64_ready !== (64'd1 << 7)) begin
            errors++;
            $display("FAIL hold_first_ready: in_ready=%h, required %h", r64_ready, 64'd1 << 7);
        end
        @(negedge clk);
        r64_valid = '0;
        checks++;
        if (r64_ovalid !== 1'b1 || r64_ochan !== 6'd7) begin
            errors++;
            $display("FAIL hold_first_out: valid=%b chan=%0d, required 1/7", r64_ovalid, r64_ochan);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (r64_ovalid !== 1'b0 || r64_ready !== '0) begin
            errors++;
            $display("FAIL hold_idle: valid=%b ready=%h, required 0/0", r64_ovalid, r64_ready);
        end
        sb.delete();
        gq.delete();
        gq.push_back(9);
        gq.push_back(2);
        sb.push_back('{chan: 9, data: 32'h1009});
        sb.push_back('{chan: 2, data: 32'h1002});
        r64_valid = (64'd1 << 2) | (64'd1 << 9);
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            guard++;
            #1;
            if (gq.size() > 0) begin
                checks++;
                if (r64_ready !== (64'd1 << gq[0])) begin
                    errors++;
                    $display("FAIL hold_ready: in_ready=%h, required %h", r64_ready, 64'd1 << gq[0]);
                end
                gq.pop_front();
            end
            @(negedge clk);
            if (r64_ovalid) begin
                checks++;
                if (r64_ochan !== 6'(sb[0].chan) || r64_odata !== sb[0].data[15:0]) begin
                    errors++;
                    $display("FAIL hold_out: chan=%0d data=%h, required %0d/%h",
                             r64_ochan, r64_odata, sb[0].chan, sb[0].data[15:0]);
                end
                sb.pop_front();
            end
        end
        r64_valid = '0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL hold_timeout: %0d words outstanding, required 0", sb.size());
        end
        @(negedge clk);
        r64_oready = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 63; k++) f_data[k*32 +: 32] = 32'h01010101 * 32'(k);
        f_data[63*32 +: 32] = 32'hDEADBEEF;
        for (int k = 0; k < 40; k++) g_data[k*16 +: 16] = 16'h4000 + 16'(k);
        for (int k = 0; k < 5; k++)  r5_data[k*8 +: 8]  = 8'hA0 + 8'(k);
        for (int k = 0; k < 64; k++) r64_data[k*16 +: 16] = 16'h1000 + 16'(k);

        test_reset();
        test_fixed_select();
        test_sel_oob();
        test_backpressure();
        test_rr_wrap();
        test_rr_fairness();
        test_ptr_hold();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
